// File: rtl/dtc_seq_pkg.sv
// Shared widths, state encoding and code-range helper for the DTC sequencer.
package dtc_seq_pkg;

  localparam int DEF_FRAC_W = 16;
  localparam int DEF_INT_W  = 4;
  localparam int DEF_DTC_W  = 6;
  localparam int DEF_GAIN_W = 8;

  // Phase word handed from the accumulator to the code map.
  localparam int PH_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } seq_state_e;

  // Largest code representable in a w-bit DTC word.
  function automatic int unsigned code_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned DTC_MAX = code_max(DEF_DTC_W);

endpackage

// File: rtl/dtc_code_map.sv
// Phase-to-DTC code map: scales the phase word by a Q2.6 gain, keeps the
// upper byte of the product and clips it into the DTC code range.
module dtc_code_map
  import dtc_seq_pkg::*;
#(
  parameter int DTC_W  = DEF_DTC_W,
  parameter int GAIN_W = DEF_GAIN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PH_W-1:0]   ph,
  input  logic [GAIN_W-1:0] gain,
  output logic [DTC_W-1:0]  code,
  output logic              sat,
  output logic              valid
);

  localparam int PROD_W = PH_W + GAIN_W;
  localparam int RAW_W  = PROD_W - PH_W;
  localparam int unsigned MAX_U = code_max(DTC_W);
  localparam logic [RAW_W-1:0] MAX_RAW  = RAW_W'(MAX_U);
  localparam logic [DTC_W-1:0] MAX_CODE = DTC_W'(MAX_U);

  logic [PROD_W-1:0] prod;
  logic [RAW_W-1:0]  raw;
  logic              clip;

  // Multiply, drop the low byte, detect overrange.
  always_comb begin
    prod = PROD_W'(ph) * PROD_W'(gain);
    raw  = RAW_W'(prod >> PH_W);
    clip = (raw > MAX_RAW);
  end

  // Register the code; code/sat hold between valid results.
  always_ff @(posedge clk) begin
    if (rst) begin
      code  <= '0;
      sat   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= in_valid;
      if (in_valid) begin
        code <= clip ? MAX_CODE : raw[DTC_W-1:0];
        sat  <= clip;
      end
    end
  end

endmodule

// File: rtl/dtc_seq.sv
// Fractional-divider DTC sequencer: per divider period it advances the phase
// accumulator, issues the next modulus and a gain-normalised DTC code.
//
//   state | meaning
//   IDLE  | stopped, edges ignored
//   PRIME | one cycle: clear accumulator, load active FCW from the inputs
//   RUN   | each EDGE advances the accumulator and launches a result
module dtc_seq
  import dtc_seq_pkg::*;
#(
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int INT_W  = DEF_INT_W,
  parameter int DTC_W  = DEF_DTC_W,
  parameter int GAIN_W = DEF_GAIN_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [INT_W-1:0]  FCW_I,
  input  logic [FRAC_W-1:0] FCW_F,
  input  logic              UPD,
  input  logic [GAIN_W-1:0] GAIN,
  input  logic              EDGE,
  output logic [INT_W:0]    DIV_N,
  output logic [DTC_W-1:0]  DTC_CODE,
  output logic              VALID,
  output logic              SAT,
  output logic              UPD_ACK,
  output logic              BUSY
);

  seq_state_e state, state_nxt;

  logic [FRAC_W-1:0] acc;
  logic [INT_W-1:0]  act_i, shd_i, cur_i;
  logic [FRAC_W-1:0] act_f, shd_f, cur_f;
  logic              pending;
  logic [FRAC_W:0]   sum;
  logic              run_ok, take, use_shd, s2_load;

  logic              s1_valid;
  logic [INT_W:0]    s1_n;
  logic [PH_W-1:0]   s1_ph;

  // Edge acceptance and the FCW actually used by this edge (a pending shadow
  // takes effect on the same edge that consumes it).
  always_comb begin
    run_ok  = (state == RUN) && EN;
    take    = run_ok && EDGE;
    use_shd = take && pending;
    cur_i   = use_shd ? shd_i : act_i;
    cur_f   = use_shd ? shd_f : act_f;
    sum     = {1'b0, acc} + {1'b0, cur_f};
    s2_load = s1_valid && run_ok;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN) state_nxt = PRIME;
      PRIME:   state_nxt = EN ? RUN : IDLE;
      RUN:     if (!EN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != IDLE);
    end
  end

  // Accumulator, shadow/active FCW and stage-1 pipeline registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc      <= '0;
      act_i    <= '0;
      act_f    <= '0;
      shd_i    <= '0;
      shd_f    <= '0;
      pending  <= 1'b0;
      s1_valid <= 1'b0;
      s1_n     <= '0;
      s1_ph    <= '0;
      UPD_ACK  <= 1'b0;
    end else begin
      UPD_ACK  <= use_shd;
      s1_valid <= take;
      if (UPD) begin
        shd_i <= FCW_I;
        shd_f <= FCW_F;
      end
      case (state)
        PRIME: begin
          acc     <= '0;
          act_i   <= FCW_I;
          act_f   <= FCW_F;
          pending <= 1'b0;
        end
        RUN: begin
          if (take) begin
            acc   <= sum[FRAC_W-1:0];
            s1_n  <= {1'b0, cur_i} + (INT_W+1)'(sum[FRAC_W]);
            s1_ph <= sum[FRAC_W-1 -: PH_W];
            if (pending) begin
              act_i <= shd_i;
              act_f <= shd_f;
            end
          end
          if (UPD)
            pending <= 1'b1;
          else if (use_shd)
            pending <= 1'b0;
        end
        default: pending <= 1'b0;
      endcase
    end
  end

  // Modulus register, loaded alongside the DTC code.
  always_ff @(posedge CLK) begin
    if (RST)
      DIV_N <= '0;
    else if (s2_load)
      DIV_N <= s1_n;
  end

  dtc_code_map #(
    .DTC_W  (DTC_W),
    .GAIN_W (GAIN_W)
  ) u_code_map (
    .clk      (CLK),
    .rst      (RST),
    .in_valid (s2_load),
    .ph       (s1_ph),
    .gain     (GAIN),
    .code     (DTC_CODE),
    .sat      (SAT),
    .valid    (VALID)
  );

endmodule
